// File: rtl/x_channel_arbiter_if.sv
// Requester-side and X-channel handshake bundle for x_channel_arbiter.
// master = requesters/downstream consumer, slave = the arbiter.
interface x_channel_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] io_req_valid;
  logic [N_REQ-1:0] io_req_ready;
  logic             io_x_valid;
  logic             io_x_ready;
  logic [ID_W-1:0]  io_x_id;

  modport master (
    output io_req_valid, io_x_ready,
    input  io_req_ready, io_x_valid, io_x_id
  );

  modport slave (
    input  io_req_valid, io_x_ready,
    output io_req_ready, io_x_valid, io_x_id
  );
endinterface

// File: rtl/x_channel_arbiter.sv
// Round-robin arbiter sharing one X flush-response channel between N_REQ requesters via a
// DEPTH-entry winner-ID FIFO. Define X_ARB_STATS_EN to add the saturating io_grant_count port.
module x_channel_arbiter #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  x_channel_arbiter_if.slave    bus,
  output logic                  io_busy
`ifdef X_ARB_STATS_EN
  ,
  output logic [15:0]           io_grant_count
`endif
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [DEPTH-1:0][ID_W-1:0]  fifo_q;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic            full, fire, deq;

  // N_REQ need not be a power of two, so wrap explicitly
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int k);
    return ID_W'((int'(a) + k) % N_REQ);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && bus.io_req_valid[wrap_add(rr_ptr_q, k)]) begin
        win_found = 1'b1;
        win_id    = wrap_add(rr_ptr_q, k);
      end
    end
  end

  assign full     = (count_q == CNT_W'(DEPTH));
  assign rr_ptr_d = wrap_add(win_id, 1);

  // Ready ignores io_x_ready: a full FIFO blocks enqueue even when a dequeue is in flight
  always_comb begin
    bus.io_req_ready = '0;
    if (!reset && win_found && !full) bus.io_req_ready[win_id] = 1'b1;
  end

  assign fire           = |bus.io_req_ready;
  assign bus.io_x_valid = (count_q != '0);
  assign bus.io_x_id    = bus.io_x_valid ? fifo_q[rd_ptr_q] : '0;
  assign deq            = bus.io_x_valid & bus.io_x_ready;
  assign io_busy        = bus.io_x_valid | (|bus.io_req_valid);

  always_comb begin
    count_d = count_q;
    case ({fire, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (fire) begin
        rr_ptr_q <= rr_ptr_d;
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: entries are only read while count_q covers them
  always_ff @(posedge clock) begin
    if (fire) fifo_q[wr_ptr_q] <= win_id;
  end

`ifdef X_ARB_STATS_EN
  logic [15:0] grant_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          grant_q <= '0;
    else if (fire && grant_q != 16'hFFFF) grant_q <= grant_q + 16'd1;
  end

  assign io_grant_count = grant_q;
`endif
endmodule

// File: tb/tb_x_channel_arbiter.sv
// Directed-vector bench for x_channel_arbiter (N_REQ=4, DEPTH=2).
module tb_x_channel_arbiter;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset;
  logic io_busy;
`ifdef X_ARB_STATS_EN
  logic [15:0] io_grant_count;
`endif

  x_channel_arbiter_if #(.N_REQ(N)) bus ();

  x_channel_arbiter #(.N_REQ(N), .DEPTH(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .io_busy        (io_busy)
`ifdef X_ARB_STATS_EN
    ,
    .io_grant_count (io_grant_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later
  task automatic drive(input logic [3:0] rv, input logic xr);
    bus.io_req_valid = rv;
    bus.io_x_ready   = xr;
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.io_req_valid = '0;
    bus.io_x_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state: ready held low even with every request raised
    reset = 1'b1;
    drive(4'b1111, 1'b0);
    chk("rst_rdy", bus.io_req_ready, 0);
    chk("rst_xv",  bus.io_x_valid, 0);
    chk("rst_xid", bus.io_x_id, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(4'b0000, 1'b0);
      chk("idle_xv",   bus.io_x_valid, 0);
      chk("idle_rdy",  bus.io_req_ready, 0);
      chk("idle_busy", io_busy, 0);
      tick();
    end

    // Single request from requester 2
    do_reset();
    drive(4'b0100, 1'b1);
    chk("single_rdy",  bus.io_req_ready, 4'b0100);
    chk("single_busy", io_busy, 1);
    tick();
    drive(4'b0000, 1'b1);
    chk("single_xv",  bus.io_x_valid, 1);
    chk("single_xid", bus.io_x_id, 2);
    tick();
    drive(4'b0000, 1'b1);
    chk("single_xv_drop", bus.io_x_valid, 0);
    chk("single_busy0",   io_busy, 0);
    tick();

    // Fairness: all four requesting, one grant per cycle in rotation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 1'b1);
      chk("fair_rdy", bus.io_req_ready, 32'(1) << (i % 4));
      if (i > 0) begin
        chk("fair_xv",  bus.io_x_valid, 1);
        chk("fair_xid", bus.io_x_id, (i - 1) % 4);
      end
      tick();
    end
    drive(4'b0000, 1'b1);
    chk("fair_last_xid", bus.io_x_id, 3);
    tick();
    drive(4'b0000, 1'b1);
    chk("fair_empty", bus.io_x_valid, 0);
    tick();

    // Backpressure: fill with 0,1, then drain while requests continue
    do_reset();
    drive(4'b0011, 1'b0); chk("bp_rdy0", bus.io_req_ready, 4'b0001); tick();
    drive(4'b0011, 1'b0); chk("bp_rdy1", bus.io_req_ready, 4'b0010);
                          chk("bp_xid_a", bus.io_x_id, 0); tick();
    drive(4'b0011, 1'b0); chk("bp_full_rdy", bus.io_req_ready, 0);
                          chk("bp_full_xv", bus.io_x_valid, 1);
                          chk("bp_hold_xid", bus.io_x_id, 0); tick();
    drive(4'b0011, 1'b0); chk("bp_full_rdy2", bus.io_req_ready, 0);
                          chk("bp_hold_xid2", bus.io_x_id, 0); tick();
    drive(4'b0011, 1'b1); chk("bp_full_deq_rdy", bus.io_req_ready, 0);
                          chk("bp_deq_xid0", bus.io_x_id, 0); tick();
    drive(4'b0011, 1'b1); chk("bp_deq_xid1", bus.io_x_id, 1);
                          chk("bp_regrant0", bus.io_req_ready, 4'b0001); tick();
    drive(4'b0011, 1'b1); chk("bp_xid_c", bus.io_x_id, 0);
                          chk("bp_regrant1", bus.io_req_ready, 4'b0010); tick();
    drive(4'b0000, 1'b1); chk("bp_xid_d", bus.io_x_id, 1); tick();
    drive(4'b0000, 1'b1); chk("bp_empty", bus.io_x_valid, 0); tick();

    // A request dropped while the FIFO is full must leave no trace
    do_reset();
    drive(4'b0011, 1'b0); tick();
    drive(4'b0011, 1'b0); tick();
    drive(4'b0100, 1'b0); chk("drop_rdy", bus.io_req_ready, 0); tick();
    drive(4'b0000, 1'b1); chk("drop_xid0", bus.io_x_id, 0); tick();
    drive(4'b0000, 1'b1); chk("drop_xid1", bus.io_x_id, 1); tick();
    drive(4'b0000, 1'b1); chk("drop_empty", bus.io_x_valid, 0); tick();

    // Skip: rr_ptr=1 with requesters 0 and 3 -> 3 first, then 0
    do_reset();
    drive(4'b0001, 1'b1); chk("skip_pre_rdy", bus.io_req_ready, 4'b0001); tick();
    drive(4'b0000, 1'b1); chk("skip_pre_xid", bus.io_x_id, 0); tick();
    drive(4'b1001, 1'b1); chk("skip_rdy3", bus.io_req_ready, 4'b1000); tick();
    drive(4'b1001, 1'b1); chk("skip_rdy0", bus.io_req_ready, 4'b0001);
                          chk("skip_xid3", bus.io_x_id, 3); tick();
    drive(4'b0000, 1'b1); chk("skip_xid0", bus.io_x_id, 0); tick();
    drive(4'b0000, 1'b1); chk("skip_empty", bus.io_x_valid, 0); tick();

    // Reset mid-operation with two entries queued
    do_reset();
    drive(4'b0011, 1'b0); tick();
    drive(4'b0011, 1'b0); tick();
    drive(4'b0011, 1'b0); chk("mid_xv_pre", bus.io_x_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_xv_async", bus.io_x_valid, 0);
    chk("mid_rdy",      bus.io_req_ready, 0);
    tick();
    tick();
    reset = 1'b0;
    drive(4'b0000, 1'b0);
    chk("mid_after_xv",   bus.io_x_valid, 0);
    chk("mid_after_busy", io_busy, 0);
`ifdef X_ARB_STATS_EN
    chk("stat_rst", io_grant_count, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 1'b1);
      tick();
    end
    chk("stat_three", io_grant_count, 3);
    drive(4'b1111, 1'b1);
    repeat (65540) tick();
    chk("stat_sat", io_grant_count, 16'hFFFF);
    drive(4'b0000, 1'b1);
    tick();
    chk("stat_sat_hold", io_grant_count, 16'hFFFF);
`else
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
